// File: rtl/pll_sup_pkg.sv
// Purpose: shared state encoding, widths and 24 MHz default timing for the PLL lock supervisor.
// Latency: n/a (constants and a combinational helper only).
// Backpressure: n/a.
package pll_sup_pkg;

    // FSM state encoding, also driven out on the status port
    localparam logic [1:0] ST_RESET_PLL = 2'b00;
    localparam logic [1:0] ST_WAIT_LOCK = 2'b01;
    localparam logic [1:0] ST_STABLE    = 2'b10;
    localparam logic [1:0] ST_RUN       = 2'b11;

    localparam int RELOCK_W = 8;

    // Defaults for a 24 MHz reference clock
    localparam int DEF_RST_CYCLES    = 24;      // 1 us
    localparam int DEF_LOCK_TIMEOUT  = 240000;  // 10 ms
    localparam int DEF_STABLE_CYCLES = 2400;    // 100 us
    localparam int DEF_MAX_RETRIES   = 4;
    localparam int DEF_CNT_W         = 18;

    // Saturating increment for the relock event counter
    function automatic logic [RELOCK_W-1:0] relock_sat_inc(input logic [RELOCK_W-1:0] v);
        return (v == {RELOCK_W{1'b1}}) ? v : v + RELOCK_W'(1);
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Purpose: single-bit two-stage synchronizer for flags entering the local clock domain.
// Latency: 2 clk_i edges from the first edge that samples a new level.
// Backpressure: none; level-based, pulses shorter than a clock period may be lost.
module sync_2ff (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    // Two flops in series to let metastability resolve before use
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/pll_lock_supervisor.sv
// Purpose: sequences PLL reset, waits for lock with timeout/retry, holds system reset until lock is stable.
// Latency: lock loss in RUN reaches outputs on the 3rd refclk edge after extlock is first sampled low.
// Backpressure: none; force_relock is a one-cycle request honoured only in RUN.
module pll_lock_supervisor
    import pll_sup_pkg::*;
#(
    parameter int RST_CYCLES    = DEF_RST_CYCLES,
    parameter int LOCK_TIMEOUT  = DEF_LOCK_TIMEOUT,
    parameter int STABLE_CYCLES = DEF_STABLE_CYCLES,
    parameter int MAX_RETRIES   = DEF_MAX_RETRIES,
    parameter int CNT_W         = DEF_CNT_W
) (
    input  logic                refclk,
    input  logic                rst_n,
    input  logic                extlock,
    input  logic                force_relock,
    output logic                pll_reset,
    output logic                sys_rst_n,
    output logic                locked,
    output logic                fault,
    output logic [1:0]          state,
    output logic [RELOCK_W-1:0] relock_cnt
);

    localparam int RETRY_W = $clog2(MAX_RETRIES + 1);

    localparam logic [CNT_W-1:0]   RST_LAST    = CNT_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0]   TO_LAST     = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0]   STABLE_LAST = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [RETRY_W-1:0] RETRY_MAX   = RETRY_W'(MAX_RETRIES);

    logic                lock_s;

    logic [1:0]          state_q,      state_d;
    logic [CNT_W-1:0]    cnt_q,        cnt_d;
    logic [RETRY_W-1:0]  retry_q,      retry_d;
    logic [RETRY_W-1:0]  retry_inc;
    logic                fault_q,      fault_d;
    logic [RELOCK_W-1:0] relock_q,     relock_d;
    logic                pll_reset_q,  pll_reset_d;
    logic                sys_rst_n_q,  sys_rst_n_d;
    logic                locked_q,     locked_d;

    // extlock comes straight from the PLL, asynchronous to refclk
    sync_2ff u_lock_sync (
        .clk_i  (refclk),
        .rst_ni (rst_n),
        .d_i    (extlock),
        .q_o    (lock_s)
    );

    // State, counters and registered outputs; outputs load the decode of next state
    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_RESET_PLL;
            cnt_q       <= '0;
            retry_q     <= '0;
            fault_q     <= 1'b0;
            relock_q    <= '0;
            pll_reset_q <= 1'b1;
            sys_rst_n_q <= 1'b0;
            locked_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            retry_q     <= retry_d;
            fault_q     <= fault_d;
            relock_q    <= relock_d;
            pll_reset_q <= pll_reset_d;
            sys_rst_n_q <= sys_rst_n_d;
            locked_q    <= locked_d;
        end
    end

    // Next-state logic plus the retry, fault and relock bookkeeping tied to transitions
    always_comb begin
        state_d   = state_q;
        retry_d   = retry_q;
        fault_d   = fault_q;
        relock_d  = relock_q;
        retry_inc = (retry_q == RETRY_MAX) ? retry_q : retry_q + RETRY_W'(1);

        case (state_q)
            ST_RESET_PLL: begin
                if (cnt_q == RST_LAST) begin
                    state_d = ST_WAIT_LOCK;
                end
            end
            ST_WAIT_LOCK: begin
                if (lock_s) begin
                    state_d = ST_STABLE;
                end else if (cnt_q == TO_LAST) begin
                    // Timed out: pulse reset again; fault is sticky and never stops retrying
                    state_d = ST_RESET_PLL;
                    retry_d = retry_inc;
                    if (retry_inc == RETRY_MAX) begin
                        fault_d = 1'b1;
                    end
                end
            end
            ST_STABLE: begin
                if (!lock_s) begin
                    state_d = ST_WAIT_LOCK;
                end else if (cnt_q == STABLE_LAST) begin
                    state_d = ST_RUN;
                    retry_d = '0;
                end
            end
            ST_RUN: begin
                // Lock loss and a software request on the same edge count once
                if (!lock_s || force_relock) begin
                    state_d  = ST_RESET_PLL;
                    relock_d = relock_sat_inc(relock_q);
                end
            end
            default: begin
                state_d = ST_RESET_PLL;
            end
        endcase

        cnt_d = (state_d != state_q) ? '0 : cnt_q + CNT_W'(1);
    end

    // Output decode of the next state so the output flops switch with state_q
    always_comb begin
        pll_reset_d = (state_d == ST_RESET_PLL);
        sys_rst_n_d = (state_d == ST_RUN);
        locked_d    = (state_d == ST_RUN);
    end

    assign pll_reset  = pll_reset_q;
    assign sys_rst_n  = sys_rst_n_q;
    assign locked     = locked_q;
    assign fault      = fault_q;
    assign state      = state_q;
    assign relock_cnt = relock_q;

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Purpose: directed self-checking bench for pll_lock_supervisor with shortened timing constants.
// Latency: expectations are queued when stimulus is applied and checked at the edge they are due.
// Backpressure: n/a.
module tb_pll_lock_supervisor;
    import pll_sup_pkg::*;

    typedef struct packed {
        logic [1:0] st;
        logic       pr;
        logic       srn;
        logic       lk;
        logic       flt;
        logic [7:0] rc;
    } obs_t;

    logic       refclk;
    logic       rst_n;
    logic       extlock;
    logic       force_relock;
    logic       pll_reset;
    logic       sys_rst_n;
    logic       locked;
    logic       fault;
    logic [1:0] state;
    logic [7:0] relock_cnt;

    int checks = 0;
    int errors = 0;

    obs_t  exp_q[$];
    string tag_q[$];

    pll_lock_supervisor #(
        .RST_CYCLES    (4),
        .LOCK_TIMEOUT  (20),
        .STABLE_CYCLES (8),
        .MAX_RETRIES   (2),
        .CNT_W         (8)
    ) dut (
        .refclk       (refclk),
        .rst_n        (rst_n),
        .extlock      (extlock),
        .force_relock (force_relock),
        .pll_reset    (pll_reset),
        .sys_rst_n    (sys_rst_n),
        .locked       (locked),
        .fault        (fault),
        .state        (state),
        .relock_cnt   (relock_cnt)
    );

    initial refclk = 1'b0;
    always #5 refclk = ~refclk;

    // Expected output vector for a given state: pll_reset only in RESET_PLL, release and locked only in RUN
    function automatic obs_t mk(input logic [1:0] st, input logic flt, input logic [7:0] rc);
        obs_t o;
        o.st  = st;
        o.pr  = (st == ST_RESET_PLL);
        o.srn = (st == ST_RUN);
        o.lk  = (st == ST_RUN);
        o.flt = flt;
        o.rc  = rc;
        return o;
    endfunction

    task automatic expect_out(input string tag, input obs_t e);
        exp_q.push_back(e);
        tag_q.push_back(tag);
    endtask

    task automatic check_out();
        obs_t  e;
        obs_t  got;
        string tag;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $error("FAIL scoreboard_empty: got no expectation, required one queued");
        end else begin
            e   = exp_q.pop_front();
            tag = tag_q.pop_front();
            got = {state, pll_reset, sys_rst_n, locked, fault, relock_cnt};
            assert (got === e) else begin
                errors++;
                $error("FAIL %s: got st=%0d pr=%b srn=%b lk=%b flt=%b rc=%0d, expected st=%0d pr=%b srn=%b lk=%b flt=%b rc=%0d",
                       tag, got.st, got.pr, got.srn, got.lk, got.flt, got.rc,
                       e.st, e.pr, e.srn, e.lk, e.flt, e.rc);
            end
        end
    endtask

    // Advance n rising edges and settle 1 time unit past the last one
    task automatic tick(input int n);
        repeat (n) @(posedge refclk);
        #1;
    endtask

    // Bounded wait for a target state
    task automatic wait_state(input logic [1:0] tgt, input int budget, input string tag);
        int n;
        n = 0;
        while (state !== tgt && n < budget) begin
            tick(1);
            n++;
        end
        checks++;
        assert (state === tgt) else begin
            errors++;
            $error("FAIL %s: state=%0d after %0d edges, required %0d", tag, state, n, tgt);
        end
    endtask

    initial begin
        int exp_rc;

        rst_n        = 1'b0;
        extlock      = 1'b0;
        force_relock = 1'b0;

        #12;
        expect_out("reset_vals", mk(ST_RESET_PLL, 1'b0, 8'd0));
        check_out();

        // Release reset between edges; the next rising edge is edge 1
        @(posedge refclk);
        #1;
        rst_n = 1'b1;
        expect_out("rp_edge3",   mk(ST_RESET_PLL, 1'b0, 8'd0));
        expect_out("wait_edge4", mk(ST_WAIT_LOCK, 1'b0, 8'd0));
        tick(3); check_out();
        tick(1); check_out();

        // Lock arrives, first sampled at edge 10
        tick(5);
        extlock = 1'b1;
        expect_out("wait_edge11",   mk(ST_WAIT_LOCK, 1'b0, 8'd0));
        expect_out("stable_edge12", mk(ST_STABLE,    1'b0, 8'd0));
        expect_out("stable_edge19", mk(ST_STABLE,    1'b0, 8'd0));
        expect_out("run_edge20",    mk(ST_RUN,       1'b0, 8'd0));
        tick(2); check_out();
        tick(1); check_out();
        tick(7); check_out();
        tick(1); check_out();

        // Lock loss in RUN: reset reasserted on the 3rd edge after first low sample
        extlock = 1'b0;
        expect_out("loss_edge2", mk(ST_RUN,       1'b0, 8'd0));
        expect_out("loss_edge3", mk(ST_RESET_PLL, 1'b0, 8'd1));
        tick(2); check_out();
        tick(1); check_out();

        // One lock timeout with MAX_RETRIES=2: no fault yet
        expect_out("to1_rp_hold",  mk(ST_RESET_PLL, 1'b0, 8'd1));
        expect_out("to1_wait",     mk(ST_WAIT_LOCK, 1'b0, 8'd1));
        expect_out("to1_wait_end", mk(ST_WAIT_LOCK, 1'b0, 8'd1));
        expect_out("to1_expired",  mk(ST_RESET_PLL, 1'b0, 8'd1));
        tick(3);  check_out();
        tick(1);  check_out();
        tick(19); check_out();
        tick(1);  check_out();

        // force_relock outside RUN has no effect
        force_relock = 1'b1;
        expect_out("force_ignored", mk(ST_RESET_PLL, 1'b0, 8'd1));
        tick(1);
        force_relock = 1'b0;
        check_out();
        expect_out("wait_again", mk(ST_WAIT_LOCK, 1'b0, 8'd1));
        tick(3); check_out();

        // Lock glitch during the stable window returns to WAIT_LOCK
        extlock = 1'b1;
        expect_out("glitch_stable", mk(ST_STABLE, 1'b0, 8'd1));
        tick(3); check_out();
        tick(1);
        extlock = 1'b0;
        expect_out("glitch_hold", mk(ST_STABLE,    1'b0, 8'd1));
        expect_out("glitch_back", mk(ST_WAIT_LOCK, 1'b0, 8'd1));
        tick(2); check_out();
        tick(1); check_out();

        // Re-assert: needs a full 8-cycle window
        extlock = 1'b1;
        expect_out("restable",     mk(ST_STABLE, 1'b0, 8'd1));
        expect_out("restable_end", mk(ST_STABLE, 1'b0, 8'd1));
        expect_out("rerun",        mk(ST_RUN,    1'b0, 8'd1));
        tick(3); check_out();
        tick(7); check_out();
        tick(1); check_out();

        // Retry count was cleared in RUN: first timeout no fault, second sets it
        extlock = 1'b0;
        expect_out("loss2",      mk(ST_RESET_PLL, 1'b0, 8'd2));
        expect_out("loss2_wait", mk(ST_WAIT_LOCK, 1'b0, 8'd2));
        expect_out("timeout_a",  mk(ST_RESET_PLL, 1'b0, 8'd2));
        expect_out("rp_a_hold",  mk(ST_RESET_PLL, 1'b0, 8'd2));
        expect_out("wait_b",     mk(ST_WAIT_LOCK, 1'b0, 8'd2));
        expect_out("timeout_b",  mk(ST_RESET_PLL, 1'b1, 8'd2));
        tick(3);  check_out();
        tick(4);  check_out();
        tick(20); check_out();
        tick(3);  check_out();
        tick(1);  check_out();
        tick(20); check_out();

        // Fault does not block recovery
        extlock = 1'b1;
        expect_out("fault_wait",       mk(ST_WAIT_LOCK, 1'b1, 8'd2));
        expect_out("fault_stable",     mk(ST_STABLE,    1'b1, 8'd2));
        expect_out("fault_stable_end", mk(ST_STABLE,    1'b1, 8'd2));
        expect_out("fault_run",        mk(ST_RUN,       1'b1, 8'd2));
        tick(4); check_out();
        tick(1); check_out();
        tick(7); check_out();
        tick(1); check_out();

        // force_relock on the edge where the FSM first sees lock_s low: one increment
        extlock = 1'b0;
        expect_out("pre_simul",   mk(ST_RUN,       1'b1, 8'd2));
        expect_out("simul_exit",  mk(ST_RESET_PLL, 1'b1, 8'd3));
        expect_out("simul_after", mk(ST_RESET_PLL, 1'b1, 8'd3));
        tick(2); check_out();
        force_relock = 1'b1;
        tick(1);
        force_relock = 1'b0;
        check_out();
        tick(1); check_out();

        // 260 forced relocks: counter saturates at 255
        extlock = 1'b1;
        for (int i = 0; i < 260; i++) begin
            wait_state(ST_RUN, 40, "relock_loop_run");
            exp_rc = 3 + i + 1;
            if (exp_rc > 255) exp_rc = 255;
            force_relock = 1'b1;
            expect_out("relock_loop", mk(ST_RESET_PLL, 1'b1, 8'(exp_rc)));
            tick(1);
            force_relock = 1'b0;
            check_out();
        end
        expect_out("relock_sat", mk(ST_RESET_PLL, 1'b1, 8'd255));
        check_out();

        // Async reset mid-STABLE: immediate reset values, fault cleared
        wait_state(ST_STABLE, 40, "reach_stable");
        tick(2);
        #2;
        rst_n = 1'b0;
        #1;
        expect_out("arst_stable", mk(ST_RESET_PLL, 1'b0, 8'd0));
        check_out();
        tick(2);
        rst_n = 1'b1;

        // Async reset mid-RUN
        wait_state(ST_RUN, 40, "reach_run_after_arst");
        expect_out("run_after_arst", mk(ST_RUN, 1'b0, 8'd0));
        check_out();
        tick(1);
        #2;
        rst_n = 1'b0;
        #1;
        expect_out("arst_run", mk(ST_RESET_PLL, 1'b0, 8'd0));
        check_out();

        // After release, a full RST_CYCLES pulse again
        tick(2);
        rst_n = 1'b1;
        expect_out("post_arst_rp3", mk(ST_RESET_PLL, 1'b0, 8'd0));
        expect_out("post_arst_wl4", mk(ST_WAIT_LOCK, 1'b0, 8'd0));
        tick(3); check_out();
        tick(1); check_out();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
